// File: rtl/cpu_defs.sv
// Shared encodings for the sequencer: opcodes, ALU codes, FSM states, IR field
// positions and the decoded control bundle.
package cpu_defs;

    localparam int REG_SEL_W = 3;
    localparam int DATA_W    = 8;
    localparam int OPC_W     = 5;
    localparam int ALU_OP_W  = 3;

    localparam int OPC_LSB = 11;
    localparam int RX_LSB  = 8;
    localparam int RY_LSB  = 5;
    localparam int IND_BIT = 4;
    localparam int IMM_LSB = 0;

    localparam logic [OPC_W-1:0] OP_NOP  = 5'd0;
    localparam logic [OPC_W-1:0] OP_MOV  = 5'd1;
    localparam logic [OPC_W-1:0] OP_MOVI = 5'd2;
    localparam logic [OPC_W-1:0] OP_ADD  = 5'd3;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'd4;
    localparam logic [OPC_W-1:0] OP_AND  = 5'd5;
    localparam logic [OPC_W-1:0] OP_OR   = 5'd6;
    localparam logic [OPC_W-1:0] OP_JMP  = 5'd7;
    localparam logic [OPC_W-1:0] OP_JZ   = 5'd8;
    localparam logic [OPC_W-1:0] OP_HALT = 5'd31;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 3'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'd3;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_WRITEBACK = 3'd3,
        S_HALT      = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        BUS_NONE = 2'd0,
        BUS_REG  = 2'd1,
        BUS_ALU  = 2'd2,
        BUS_IMM  = 2'd3
    } bus_src_t;

    typedef struct packed {
        logic                 writes_rx;
        logic                 uses_ry;
        bus_src_t             bus_src;
        logic [ALU_OP_W-1:0]  alu_op;
        logic                 is_alu;
        logic                 indirect;
        logic                 is_jump;
        logic                 is_jz;
        logic                 is_halt;
        logic                 illegal;
        logic [REG_SEL_W-1:0] rx;
        logic [REG_SEL_W-1:0] ry;
        logic [DATA_W-1:0]    imm;
    } ctrl_t;

    function automatic logic [ALU_OP_W-1:0] alu_code(input logic [OPC_W-1:0] op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/opcode_decoder.sv
// Purely combinational IR -> control bundle; the sequencer gates it by state.
module opcode_decoder
    import cpu_defs::*;
(
    input  logic [15:0] i_ir,
    output ctrl_t       o_ctrl
);

    logic [OPC_W-1:0] w_opc;
    assign w_opc = i_ir[OPC_LSB +: OPC_W];

    always_comb begin
        o_ctrl         = '0;
        o_ctrl.bus_src = BUS_NONE;
        o_ctrl.rx      = i_ir[RX_LSB +: REG_SEL_W];
        o_ctrl.ry      = i_ir[RY_LSB +: REG_SEL_W];
        o_ctrl.imm     = i_ir[IMM_LSB +: DATA_W];
        case (w_opc)
            OP_NOP: ;
            OP_MOV: begin
                o_ctrl.writes_rx = 1'b1;
                o_ctrl.uses_ry   = 1'b1;
                o_ctrl.bus_src   = BUS_REG;
                o_ctrl.indirect  = i_ir[IND_BIT];
            end
            OP_MOVI: begin
                o_ctrl.writes_rx = 1'b1;
                o_ctrl.bus_src   = BUS_IMM;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                // ALU reads rx/ry straight from the bank; the bus carries only the result
                o_ctrl.writes_rx = 1'b1;
                o_ctrl.uses_ry   = 1'b1;
                o_ctrl.bus_src   = BUS_ALU;
                o_ctrl.is_alu    = 1'b1;
                o_ctrl.alu_op    = alu_code(w_opc);
            end
            OP_JMP:  o_ctrl.is_jump = 1'b1;
            OP_JZ:   o_ctrl.is_jz   = 1'b1;
            OP_HALT: o_ctrl.is_halt = 1'b1;
            default: o_ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Four-cycle fetch/decode/execute/writeback sequencer driving the 8x8 register
// bank, ALU and bus enables; owns PC, IR and the latched zero flag.
module control_sequencer
    import cpu_defs::*;
#(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [PC_WIDTH-1:0]    out_pc_addr,
    input  logic [INSTR_WIDTH-1:0] in_instruction,
    output logic [REG_SEL_W-1:0]   out_rx_selector,
    output logic [REG_SEL_W-1:0]   out_ry_selector,
    output logic                   out_read_en,
    output logic                   out_write_en,
    output logic                   out_indirect_mode_en,
    output logic [ALU_OP_W-1:0]    out_alu_op,
    output logic                   out_alu_drive_en,
    output logic                   out_imm_en,
    output logic [DATA_W-1:0]      out_imm_data,
    input  logic                   in_alu_zero,
    output logic                   out_halted,
    output logic                   out_illegal
);

    state_t                 r_state;
    logic [PC_WIDTH-1:0]    r_pc;
    logic [INSTR_WIDTH-1:0] r_ir;
    logic                   r_zflag;

    state_t                 w_state_nxt;
    logic [PC_WIDTH-1:0]    w_pc_nxt;
    logic [PC_WIDTH-1:0]    w_imm_pc;
    logic                   w_drive;
    ctrl_t                  w_ctrl;

    opcode_decoder u_dec (
        .i_ir   (r_ir[15:0]),
        .o_ctrl (w_ctrl)
    );

    assign w_imm_pc = PC_WIDTH'(w_ctrl.imm);
    assign w_drive  = (r_state == S_EXECUTE) || (r_state == S_WRITEBACK);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_pc    <= '0;
            r_ir    <= '0;
            r_zflag <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_DECODE)
                r_ir <= in_instruction;
            if (r_state == S_WRITEBACK) begin
                r_pc <= w_pc_nxt;
                if (w_ctrl.is_alu)
                    r_zflag <= in_alu_zero;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FETCH:     w_state_nxt = S_DECODE;
            S_DECODE:    w_state_nxt = S_EXECUTE;
            S_EXECUTE:   w_state_nxt = w_ctrl.is_halt ? S_HALT : S_WRITEBACK;
            S_WRITEBACK: w_state_nxt = S_FETCH;
            S_HALT:      w_state_nxt = S_HALT;
            default:     w_state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        w_pc_nxt = r_pc + PC_WIDTH'(1);
        if (w_ctrl.is_jump || (w_ctrl.is_jz && r_zflag))
            w_pc_nxt = w_imm_pc;
    end

    always_comb begin
        out_pc_addr          = '0;
        out_rx_selector      = '0;
        out_ry_selector      = '0;
        out_read_en          = 1'b0;
        out_write_en         = 1'b0;
        out_indirect_mode_en = 1'b0;
        out_alu_op           = '0;
        out_alu_drive_en     = 1'b0;
        out_imm_en           = 1'b0;
        out_imm_data         = '0;
        out_halted           = (r_state == S_HALT);
        out_illegal          = (r_state == S_EXECUTE) && w_ctrl.illegal;

        if ((r_state == S_FETCH) || (r_state == S_DECODE))
            out_pc_addr = r_pc;

        // Held identically over EXECUTE and WRITEBACK so the bank's write edge sees stable selects
        if (w_drive) begin
            if (w_ctrl.writes_rx)
                out_rx_selector = w_ctrl.rx;
            if (w_ctrl.uses_ry)
                out_ry_selector = w_ctrl.ry;
            out_read_en          = (w_ctrl.bus_src == BUS_REG);
            out_alu_drive_en     = (w_ctrl.bus_src == BUS_ALU);
            out_imm_en           = (w_ctrl.bus_src == BUS_IMM);
            out_indirect_mode_en = w_ctrl.indirect;
            out_alu_op           = w_ctrl.alu_op;
            if (w_ctrl.bus_src == BUS_IMM)
                out_imm_data = w_ctrl.imm;
        end

        // Reset arriving during WRITEBACK must suppress the bank write on that same edge
        out_write_en = (r_state == S_WRITEBACK) && w_ctrl.writes_rx && rst_n;
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: a behavioural synchronous ROM feeds
// hand-assembled programs and outputs are checked at negedges.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  out_pc_addr;
    logic [15:0] in_instruction;
    logic [2:0]  out_rx_selector;
    logic [2:0]  out_ry_selector;
    logic        out_read_en;
    logic        out_write_en;
    logic        out_indirect_mode_en;
    logic [2:0]  out_alu_op;
    logic        out_alu_drive_en;
    logic        out_imm_en;
    logic [7:0]  out_imm_data;
    logic        in_alu_zero;
    logic        out_halted;
    logic        out_illegal;

    logic [15:0] rom [256];
    logic [22:0] w_others;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;

    control_sequencer #(.PC_WIDTH(8), .INSTR_WIDTH(16)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .out_pc_addr          (out_pc_addr),
        .in_instruction       (in_instruction),
        .out_rx_selector      (out_rx_selector),
        .out_ry_selector      (out_ry_selector),
        .out_read_en          (out_read_en),
        .out_write_en         (out_write_en),
        .out_indirect_mode_en (out_indirect_mode_en),
        .out_alu_op           (out_alu_op),
        .out_alu_drive_en     (out_alu_drive_en),
        .out_imm_en           (out_imm_en),
        .out_imm_data         (out_imm_data),
        .in_alu_zero          (in_alu_zero),
        .out_halted           (out_halted),
        .out_illegal          (out_illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) in_instruction <= rom[out_pc_addr];

    // Everything except pc_addr and halted, for "all quiet" checks
    assign w_others = {out_rx_selector, out_ry_selector, out_read_en, out_write_en,
                       out_indirect_mode_en, out_alu_op, out_alu_drive_en, out_imm_en,
                       out_imm_data, out_illegal};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    task automatic go_to(input int t);
        repeat (t - cyc) @(negedge clk);
        cyc = t;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    endtask

    initial begin
        rst_n       = 1'b0;
        in_alu_zero = 1'b0;
        clear_rom();
        rom[0] = 16'h1355;                       // MOVI r3,0x55
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cyc   = 1;
        #1;
        chk("reset_pc_addr", out_pc_addr, 8'h00);
        chk("reset_others", w_others, 23'h0);
        chk("reset_halted", out_halted, 1'b0);

        // MOVI r3,0x55 then reset during its WRITEBACK
        go_to(3);
        chk("movi_exec_imm_en", out_imm_en, 1'b1);
        chk("movi_exec_imm_data", out_imm_data, 8'h55);
        chk("movi_exec_rx", out_rx_selector, 3'd3);
        chk("movi_exec_we", out_write_en, 1'b0);
        go_to(4);
        chk("movi_wb_we", out_write_en, 1'b1);
        rst_n = 1'b0;
        clear_rom();
        rom[8'h00] = 16'h110A;                   // MOVI r1,0x0A
        rom[8'h01] = 16'h120A;                   // MOVI r2,0x0A
        rom[8'h02] = 16'h2140;                   // SUB r1,r2
        rom[8'h03] = 16'h4010;                   // JZ 0x10
        rom[8'h10] = 16'h0C50;                   // MOV r4,[r2]
        rom[8'h11] = 16'h38FF;                   // JMP 0xFF
        rom[8'hFF] = 16'h0000;                   // NOP
        in_alu_zero = 1'b1;
        #1;
        chk("rst_in_wb_we", out_write_en, 1'b0);
        go_to(5);
        rst_n = 1'b1;
        cyc   = 1;
        #1;
        chk("post_rst_we", out_write_en, 1'b0);
        chk("post_rst_pc_addr", out_pc_addr, 8'h00);
        chk("post_rst_others", w_others, 23'h0);

        // SUB / JZ program
        go_to(5);
        chk("fetch2_pc_addr", out_pc_addr, 8'h01);
        go_to(11);
        chk("sub_exec_alu_op", out_alu_op, 3'd1);
        chk("sub_exec_alu_drive", out_alu_drive_en, 1'b1);
        chk("sub_exec_read_en", out_read_en, 1'b0);
        chk("sub_exec_imm_en", out_imm_en, 1'b0);
        chk("sub_exec_we", out_write_en, 1'b0);
        chk("sub_exec_rx", out_rx_selector, 3'd1);
        chk("sub_exec_ry", out_ry_selector, 3'd2);
        go_to(12);
        chk("sub_wb_we", out_write_en, 1'b1);
        chk("sub_wb_alu_op", out_alu_op, 3'd1);
        go_to(13);
        chk("jz_fetch_pc_addr", out_pc_addr, 8'h03);
        go_to(15);
        chk("jz_exec_others", w_others, 23'h0);
        go_to(17);
        chk("jz_taken_pc_addr", out_pc_addr, 8'h10);

        // MOV r4,[r2] indirect
        go_to(19);
        chk("mov_exec_read_en", out_read_en, 1'b1);
        chk("mov_exec_ind", out_indirect_mode_en, 1'b1);
        chk("mov_exec_rx", out_rx_selector, 3'd4);
        chk("mov_exec_ry", out_ry_selector, 3'd2);
        chk("mov_exec_we", out_write_en, 1'b0);
        chk("mov_exec_alu_drive", out_alu_drive_en, 1'b0);
        go_to(20);
        chk("mov_wb_we", out_write_en, 1'b1);
        chk("mov_wb_read_en", out_read_en, 1'b1);
        chk("mov_wb_ind", out_indirect_mode_en, 1'b1);
        chk("mov_wb_rx", out_rx_selector, 3'd4);

        // JMP 0xFF, NOP at 0xFF wraps to 0
        go_to(23);
        chk("jmp_exec_others", w_others, 23'h0);
        go_to(25);
        chk("jmp_pc_addr", out_pc_addr, 8'hFF);
        go_to(29);
        chk("wrap_pc_addr", out_pc_addr, 8'h00);

        // Illegal opcode, untaken JZ, JMP 5, HALT
        rst_n = 1'b0;
        clear_rom();
        rom[8'h00] = 16'hF000;                   // opcode 0x1E
        rom[8'h01] = 16'h4040;                   // JZ 0x40 with zflag clear
        rom[8'h02] = 16'h3805;                   // JMP 5
        rom[8'h05] = 16'hF800;                   // HALT
        in_alu_zero = 1'b0;
        go_to(30);
        rst_n = 1'b1;
        cyc   = 1;
        #1;
        chk("rst2_pc_addr", out_pc_addr, 8'h00);
        go_to(3);
        chk("illegal_pulse", out_illegal, 1'b1);
        chk("illegal_we", out_write_en, 1'b0);
        go_to(4);
        chk("illegal_pulse_end", out_illegal, 1'b0);
        chk("illegal_wb_we", out_write_en, 1'b0);
        go_to(5);
        chk("illegal_next_pc", out_pc_addr, 8'h01);
        go_to(9);
        chk("jz_untaken_pc", out_pc_addr, 8'h02);
        go_to(13);
        chk("halt_fetch_pc", out_pc_addr, 8'h05);
        go_to(15);
        chk("halt_exec_halted", out_halted, 1'b0);
        chk("halt_exec_others", w_others, 23'h0);
        for (int t = 16; t < 40; t++) begin
            go_to(t);
            chk("halted_flag", out_halted, 1'b1);
            chk("halted_pc_addr", out_pc_addr, 8'h00);
            chk("halted_others", w_others, 23'h0);
        end
        rst_n = 1'b0;
        go_to(40);
        chk("halt_reset_halted", out_halted, 1'b0);
        chk("halt_reset_pc_addr", out_pc_addr, 8'h00);
        rst_n = 1'b1;
        go_to(41);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
